// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Memory-read and decoder-issue handshakes of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
    parameter int INST_WIDTH = 16,
    parameter int PC_WIDTH   = 8
);
    logic                  mem_read_valid;
    logic [PC_WIDTH-1:0]   mem_read_address;
    logic                  mem_read_ready;
    logic [INST_WIDTH-1:0] mem_read_data;
    logic [INST_WIDTH-1:0] instruction;
    logic                  instruction_valid;
    logic                  instruction_ready;
    logic                  branch_taken;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [PC_WIDTH-1:0]   pc;
    logic                  done;

    // The fetch stage is the master of both the memory and the issue side.
    modport master (
        input  mem_read_ready, mem_read_data, instruction_ready,
               branch_taken, branch_target,
        output mem_read_valid, mem_read_address, instruction,
               instruction_valid, pc, done
    );

    modport slave (
        output mem_read_ready, mem_read_data, instruction_ready,
               branch_taken, branch_target,
        input  mem_read_valid, mem_read_address, instruction,
               instruction_valid, pc, done
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : PC sequencer issuing memory reads and presenting instructions.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int         INST_WIDTH  = 16,
    parameter int         PC_WIDTH    = 8,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start,
    input  wire logic [PC_WIDTH-1:0] start_pc,
    instruction_fetch_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] c_pc_one = PC_WIDTH'(1);

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_mem_read_address;
    logic                  r_mem_read_valid;
    logic [INST_WIDTH-1:0] r_instruction;
    logic                  r_instruction_valid;
    logic                  r_done;

    logic                  w_halt;
    logic [PC_WIDTH-1:0]   w_pc_next;

    assign w_halt    = (r_instruction[INST_WIDTH-1 -: 4] == HALT_OPCODE);
    assign w_pc_next = bus.branch_taken ? bus.branch_target : (r_pc + c_pc_one);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= IDLE;
            r_pc                <= '0;
            r_mem_read_address  <= '0;
            r_mem_read_valid    <= 1'b0;
            r_instruction       <= '0;
            r_instruction_valid <= 1'b0;
            r_done              <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state            <= FETCH;
                        r_pc               <= start_pc;
                        r_mem_read_address <= start_pc;
                        r_mem_read_valid   <= 1'b1;
                        r_done             <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.mem_read_ready) begin
                        r_state             <= ISSUE;
                        r_instruction       <= bus.mem_read_data;
                        r_mem_read_valid    <= 1'b0;
                        r_instruction_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.instruction_ready) begin
                        r_instruction_valid <= 1'b0;
                        // A halt wins over any redirect presented with it.
                        if (w_halt) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state            <= FETCH;
                            r_pc               <= w_pc_next;
                            r_mem_read_address <= w_pc_next;
                            r_mem_read_valid   <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read_valid    = r_mem_read_valid;
    assign bus.mem_read_address  = r_mem_read_address;
    assign bus.instruction       = r_instruction;
    assign bus.instruction_valid = r_instruction_valid;
    assign bus.pc                = r_pc;
    assign bus.done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed and randomized checks of instruction_fetch against a program model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_pc;

    always #5 clk = ~clk;

    instruction_fetch_if #(.INST_WIDTH(16), .PC_WIDTH(8)) bus ();

    instruction_fetch #(
        .INST_WIDTH (16),
        .PC_WIDTH   (8),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .start_pc(start_pc),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Program model: memory image, expected PC and halt flag.
    logic [15:0] mem [256];
    int          m_pc;
    bit          halted;
    int          issue_cyc;
    int          start_cyc;
    int          prev_issue;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mrv"},  bus.mem_read_valid,    0);
        check({tag, "_addr"}, bus.mem_read_address,  0);
        check({tag, "_inst"}, bus.instruction,       0);
        check({tag, "_iv"},   bus.instruction_valid, 0);
        check({tag, "_pc"},   bus.pc,                0);
        check({tag, "_done"}, bus.done,              0);
    endtask

    task automatic do_start(input logic [7:0] spc);
        start     = 1'b1;
        start_pc  = spc;
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        start_pc = 8'($urandom);
        m_pc     = int'(spc);
        halted   = 1'b0;
        check("start_done_clr", bus.done, 0);
    endtask

    // One full fetch/issue/accept transaction seen from the program's point of view.
    task automatic fetch_one(input int mem_wait, input int rdy_wait, input bit br, input logic [7:0] tgt);
        logic [15:0] word;
        check("req_valid", bus.mem_read_valid,    1);
        check("req_addr",  bus.mem_read_address, m_pc);
        check("req_iv",    bus.instruction_valid, 0);
        for (int i = 0; i < mem_wait; i++) begin
            bus.mem_read_ready = 1'b0;
            bus.mem_read_data  = 16'($urandom);
            start              = 1'($urandom);
            start_pc           = 8'($urandom);
            @(negedge clk);
            check("wait_valid", bus.mem_read_valid,    1);
            check("wait_addr",  bus.mem_read_address, m_pc);
            check("wait_iv",    bus.instruction_valid, 0);
        end
        start              = 1'b0;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = mem[m_pc];
        @(negedge clk);
        issue_cyc          = cyc;
        bus.mem_read_ready = 1'b0;
        check("iss_iv",   bus.instruction_valid, 1);
        check("iss_inst", bus.instruction,       mem[m_pc]);
        check("iss_pc",   bus.pc,                m_pc);
        check("iss_mrv",  bus.mem_read_valid,    0);
        for (int i = 0; i < rdy_wait; i++) begin
            bus.instruction_ready = 1'b0;
            bus.branch_taken      = 1'($urandom);
            bus.branch_target     = 8'($urandom);
            bus.mem_read_ready    = 1'($urandom);
            bus.mem_read_data     = 16'($urandom);
            start                 = 1'($urandom);
            start_pc              = 8'($urandom);
            @(negedge clk);
            check("bp_iv",   bus.instruction_valid, 1);
            check("bp_inst", bus.instruction,       mem[m_pc]);
            check("bp_pc",   bus.pc,                m_pc);
            check("bp_mrv",  bus.mem_read_valid,    0);
        end
        bus.mem_read_ready    = 1'b0;
        start                 = 1'b0;
        bus.instruction_ready = 1'b1;
        bus.branch_taken      = br;
        bus.branch_target     = tgt;
        @(negedge clk);
        bus.instruction_ready = 1'b0;
        bus.branch_taken      = 1'b0;
        word = mem[m_pc];
        if (word[15:12] == 4'hF) begin
            halted = 1'b1;
            check("halt_done", bus.done,              1);
            check("halt_mrv",  bus.mem_read_valid,    0);
            check("halt_iv",   bus.instruction_valid, 0);
        end else begin
            m_pc = br ? int'(tgt) : (m_pc + 1) % 256;
            check("acc_done", bus.done, 0);
        end
    endtask

    initial begin
        rst_n                 = 1'b0;
        start                 = 1'b0;
        start_pc              = '0;
        bus.mem_read_ready    = 1'b0;
        bus.mem_read_data     = '0;
        bus.instruction_ready = 1'b0;
        bus.branch_taken      = 1'b0;
        bus.branch_target     = '0;
        halted                = 1'b0;
        m_pc                  = 0;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 16'($urandom);
            if (mem[a][15:12] == 4'hF) mem[a][15:12] = 4'hE;
        end
        mem[8'h10] = 16'h1234;
        mem[8'h11] = 16'h2345;
        mem[8'h00] = 16'hF000;

        // Reset values, and no fetch without start after release.
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        bus.mem_read_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_read_ready = 1'b0;
        check("idle_mrv",  bus.mem_read_valid,    0);
        check("idle_iv",   bus.instruction_valid, 0);

        // Sequential zero-wait run: latency and throughput.
        do_start(8'h10);
        fetch_one(0, 0, 1'b0, 8'h00);
        check("latency", issue_cyc - start_cyc, 2);
        prev_issue = issue_cyc;
        fetch_one(0, 0, 1'b0, 8'h00);
        check("throughput", issue_cyc - prev_issue, 2);

        // Memory wait states plus downstream backpressure at 0x12.
        fetch_one(3, 5, 1'b0, 8'h00);
        // Branch to 0x40, with branch noise during stall cycles.
        fetch_one(0, 2, 1'b1, 8'h40);
        fetch_one(0, 0, 1'b0, 8'h00);
        // Wrap 0xFF -> 0x00, then halt at 0x00.
        fetch_one(0, 0, 1'b1, 8'hFF);
        fetch_one(0, 0, 1'b0, 8'h00);
        fetch_one(0, 1, 1'b1, 8'h33);
        check("halted_flag", 32'(halted), 1);

        // Done holds with idle outputs until a new start.
        for (int i = 0; i < 3; i++) begin
            bus.mem_read_ready    = 1'($urandom);
            bus.instruction_ready = 1'($urandom);
            @(negedge clk);
            check("done_hold", bus.done,              1);
            check("done_mrv",  bus.mem_read_valid,    0);
            check("done_iv",   bus.instruction_valid, 0);
        end
        bus.mem_read_ready    = 1'b0;
        bus.instruction_ready = 1'b0;
        do_start(8'h05);
        fetch_one(0, 0, 1'b0, 8'h00);

        // Randomized program over an image that may contain halts.
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int n = 0; n < 60; n++) begin
            if (halted) do_start(8'($urandom));
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        // Asynchronous reset between clock edges while in FETCH.
        if (halted) do_start(8'($urandom));
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst");
        @(negedge clk);
        check_all_zero("arst_hold");
        rst_n = 1'b1;
        bus.mem_read_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_read_ready = 1'b0;
        check("post_rst_mrv", bus.mem_read_valid,    0);
        check("post_rst_iv",  bus.instruction_valid, 0);
        do_start(8'h07);
        fetch_one(1, 1, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
